// File: rtl/systolic_mm_tile.sv
// Output-stationary ROWS x COLS signed systolic matrix-multiply tile with built-in operand skew,
// a full-vector valid/ready input stream and a row-serial valid/ready result drain.
module systolic_mm_tile #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 48,
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int KMAX   = 256,
    localparam int K_W   = $clog2(KMAX + 1),
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [K_W-1:0]           k_len,
    input  logic                     acc_mode,
    input  logic [ROWS*DATA_W-1:0]   a_vec,
    input  logic [COLS*DATA_W-1:0]   b_vec,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [COLS*ACC_W-1:0]    c_row,
    output logic [RW-1:0]            c_row_idx,
    output logic                     c_valid,
    input  logic                     c_ready,
    output logic                     c_last,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               dbg_state
);

    localparam int FL_W = $clog2(ROWS + COLS);

    // Handshakes: a beat moves on a rising edge where valid & ready are both 1; ready never waits on valid.
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_t;

    state_t          r_state, w_state_nxt;
    logic [K_W-1:0]  r_k_len, r_k_cnt, w_k_sat;
    logic [FL_W-1:0] r_flush;
    logic [RW-1:0]   r_row;
    logic            r_fin;
    logic            w_start_ok, w_xfer, w_beat, w_clr;

    logic [DATA_W-1:0] w_ain  [ROWS];
    logic              w_ainv [ROWS];
    logic [DATA_W-1:0] w_bin  [COLS];
    logic              w_binv [COLS];
    logic [DATA_W-1:0] w_pa   [ROWS][COLS];
    logic              w_pav  [ROWS][COLS];
    logic [DATA_W-1:0] w_pb   [ROWS][COLS];
    logic              w_pbv  [ROWS][COLS];
    logic [ACC_W-1:0]  w_acc  [ROWS][COLS];

    assign w_k_sat   = (k_len > K_W'(KMAX)) ? K_W'(KMAX) : k_len;
    assign w_clr     = w_start_ok & ~acc_mode;
    assign dbg_state = r_state;

    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_xfer      = 1'b0;
        w_beat      = 1'b0;
        in_ready    = 1'b0;
        c_valid     = 1'b0;
        done        = 1'b0;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = (w_k_sat == '0) ? S_DRAIN : S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_xfer = 1'b1;
                    if (r_k_cnt == r_k_len - K_W'(1)) w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (r_flush == FL_W'(ROWS + COLS - 2)) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // r_fin marks the extra cycle after the last beat that carries the done pulse.
                if (r_fin) begin
                    done        = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    c_valid = 1'b1;
                    w_beat  = c_ready;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_k_len <= '0;
            r_k_cnt <= '0;
            r_flush <= '0;
            r_row   <= '0;
            r_fin   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_ok) begin
                r_k_len <= w_k_sat;
                r_k_cnt <= '0;
                r_flush <= '0;
                r_row   <= '0;
                r_fin   <= 1'b0;
            end
            if (w_xfer) r_k_cnt <= r_k_cnt + K_W'(1);
            if (r_state == S_FLUSH) r_flush <= r_flush + FL_W'(1);
            if (w_beat) begin
                if (r_row == RW'(ROWS - 1)) r_fin <= 1'b1;
                else r_row <= r_row + RW'(1);
            end
            if (done) begin
                r_fin <= 1'b0;
                r_row <= '0;
            end
        end
    end

    always_comb begin
        c_row     = '0;
        c_row_idx = '0;
        c_last    = 1'b0;
        if (c_valid) begin
            c_row_idx = r_row;
            c_last    = (r_row == RW'(ROWS - 1));
            for (int j = 0; j < COLS; j++) c_row[j*ACC_W +: ACC_W] = w_acc[r_row][j];
        end
    end

    // Row i of A enters i cycles late, column j of B j cycles late, each with its transfer tag.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_askew
        if (gi == 0) begin : g_direct
            assign w_ain[gi]  = a_vec[gi*DATA_W +: DATA_W];
            assign w_ainv[gi] = w_xfer;
        end else begin : g_dly
            logic [DATA_W-1:0] r_d [gi];
            logic              r_v [gi];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int d = 0; d < gi; d++) begin
                        r_d[d] <= '0;
                        r_v[d] <= 1'b0;
                    end
                end else begin
                    r_d[0] <= a_vec[gi*DATA_W +: DATA_W];
                    r_v[0] <= w_xfer;
                    for (int d = 1; d < gi; d++) begin
                        r_d[d] <= r_d[d-1];
                        r_v[d] <= r_v[d-1];
                    end
                end
            end
            assign w_ain[gi]  = r_d[gi-1];
            assign w_ainv[gi] = r_v[gi-1];
        end
    end

    for (genvar gj = 0; gj < COLS; gj++) begin : g_bskew
        if (gj == 0) begin : g_direct
            assign w_bin[gj]  = b_vec[gj*DATA_W +: DATA_W];
            assign w_binv[gj] = w_xfer;
        end else begin : g_dly
            logic [DATA_W-1:0] r_d [gj];
            logic              r_v [gj];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int d = 0; d < gj; d++) begin
                        r_d[d] <= '0;
                        r_v[d] <= 1'b0;
                    end
                end else begin
                    r_d[0] <= b_vec[gj*DATA_W +: DATA_W];
                    r_v[0] <= w_xfer;
                    for (int d = 1; d < gj; d++) begin
                        r_d[d] <= r_d[d-1];
                        r_v[d] <= r_v[d-1];
                    end
                end
            end
            assign w_bin[gj]  = r_d[gj-1];
            assign w_binv[gj] = r_v[gj-1];
        end
    end

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < COLS; gj++) begin : g_col
            logic [DATA_W-1:0]          w_a, w_b;
            logic                       w_av, w_bv;
            logic signed [2*DATA_W-1:0] w_prod;
            logic [DATA_W-1:0]          r_a, r_b;
            logic                       r_av, r_bv;
            logic [ACC_W-1:0]           r_acc;

            if (gj == 0) begin : g_aedge
                assign w_a  = w_ain[gi];
                assign w_av = w_ainv[gi];
            end else begin : g_apass
                assign w_a  = w_pa[gi][gj-1];
                assign w_av = w_pav[gi][gj-1];
            end
            if (gi == 0) begin : g_bedge
                assign w_b  = w_bin[gj];
                assign w_bv = w_binv[gj];
            end else begin : g_bpass
                assign w_b  = w_pb[gi-1][gj];
                assign w_bv = w_pbv[gi-1][gj];
            end

            assign w_prod = $signed(w_a) * $signed(w_b);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_a   <= '0;
                    r_av  <= 1'b0;
                    r_b   <= '0;
                    r_bv  <= 1'b0;
                    r_acc <= '0;
                end else begin
                    r_a  <= w_a;
                    r_av <= w_av;
                    r_b  <= w_b;
                    r_bv <= w_bv;
                    if (w_clr) r_acc <= '0;
                    else if (w_av && w_bv) r_acc <= r_acc + ACC_W'(w_prod);
                end
            end

            assign w_pa[gi][gj]  = r_a;
            assign w_pav[gi][gj] = r_av;
            assign w_pb[gi][gj]  = r_b;
            assign w_pbv[gi][gj] = r_bv;
            assign w_acc[gi][gj] = r_acc;
        end
    end

endmodule

// File: tb/tb_systolic_mm_tile.sv
// Bench for systolic_mm_tile: directed and randomized tiles checked against a plain
// matrix-product reference model with an expected-row queue.
module tb_systolic_mm_tile;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 48;
    localparam int ROWS   = 2;
    localparam int COLS   = 2;
    localparam int KMAX   = 8;
    localparam int K_W    = $clog2(KMAX + 1);
    localparam int RW     = 1;
    localparam int CW     = COLS * ACC_W;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   start = 1'b0;
    logic [K_W-1:0]         k_len = '0;
    logic                   acc_mode = 1'b0;
    logic [ROWS*DATA_W-1:0] a_vec = '0;
    logic [COLS*DATA_W-1:0] b_vec = '0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [CW-1:0]          c_row;
    logic [RW-1:0]          c_row_idx;
    logic                   c_valid;
    logic                   c_ready = 1'b0;
    logic                   c_last;
    logic                   busy;
    logic                   done;
    logic [1:0]             dbg_state;

    systolic_mm_tile #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .ROWS(ROWS), .COLS(COLS), .KMAX(KMAX)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .acc_mode(acc_mode),
        .a_vec(a_vec), .b_vec(b_vec), .in_valid(in_valid), .in_ready(in_ready),
        .c_row(c_row), .c_row_idx(c_row_idx), .c_valid(c_valid), .c_ready(c_ready),
        .c_last(c_last), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int a_m [ROWS][KMAX];
    int b_m [KMAX][COLS];
    logic signed [ACC_W-1:0] model_c [ROWS][COLS];
    logic [CW-1:0] exp_q[$];
    int            exp_idx_q[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: C = (mode ? C : 0) + A(:,0..k-1) * B(0..k-1,:), modulo 2^ACC_W.
    task automatic model_tile(input int k, input bit mode);
        logic [CW-1:0] row;
        if (!mode)
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) model_c[i][j] = '0;
        for (int kk = 0; kk < k; kk++)
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
                    model_c[i][j] = model_c[i][j] + ACC_W'(longint'(a_m[i][kk]) * longint'(b_m[kk][j]));
        for (int i = 0; i < ROWS; i++) begin
            row = '0;
            for (int j = 0; j < COLS; j++) row[j*ACC_W +: ACC_W] = model_c[i][j];
            exp_q.push_back(row);
            exp_idx_q.push_back(i);
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < KMAX; k++) begin
            for (int i = 0; i < ROWS; i++) a_m[i][k] = int'($urandom_range(0, 65535)) - 32768;
            for (int j = 0; j < COLS; j++) b_m[k][j] = int'($urandom_range(0, 65535)) - 32768;
        end
    endtask

    task automatic drive_vec(input int idx);
        for (int i = 0; i < ROWS; i++) a_vec[i*DATA_W +: DATA_W] = DATA_W'(a_m[i][idx]);
        for (int j = 0; j < COLS; j++) b_vec[j*DATA_W +: DATA_W] = DATA_W'(b_m[idx][j]);
    endtask

    task automatic do_start(input int k_req, input bit mode);
        @(negedge clk);
        chk("idle_before_start", busy, 0);
        start    = 1'b1;
        k_len    = K_W'(k_req);
        acc_mode = mode;
        @(negedge clk);
        start    = 1'b0;
        k_len    = K_W'($urandom);
        acc_mode = ~mode;
    endtask

    // vmode: 0 always valid, 1 toggle, 2 random. smode: 0 always ready, 1 random, 2 hold off 5 cycles.
    task automatic run_tile(input int k_req, input bit mode, input int vmode, input int smode, input bit poke);
        int k_eff, idx, cyc, beats, stall_cnt;
        bit xfer;
        k_eff = (k_req > KMAX) ? KMAX : k_req;
        model_tile(k_eff, mode);
        do_start(k_req, mode);
        idx = 0;
        cyc = 0;
        if (k_eff > 0) chk("in_ready_load", in_ready, 1);
        while (idx < k_eff && cyc < 200) begin
            case (vmode)
                0:       in_valid = 1'b1;
                1:       in_valid = (cyc % 2 == 0);
                default: in_valid = ($urandom_range(0, 3) != 0);
            endcase
            if (in_valid) drive_vec(idx);
            else begin
                a_vec = ROWS*DATA_W'($urandom);
                b_vec = COLS*DATA_W'($urandom);
            end
            if (poke && cyc == 1) begin
                start    = 1'b1;
                k_len    = K_W'(1);
                acc_mode = 1'b0;
            end else start = 1'b0;
            xfer = in_valid && in_ready;
            @(negedge clk);
            if (xfer) idx++;
            cyc++;
        end
        start = 1'b0;
        chk("xfer_count", idx, k_eff);
        chk("in_ready_after_load", in_ready, 0);
        beats     = 0;
        cyc       = 0;
        stall_cnt = 0;
        while (beats < ROWS && cyc < 300) begin
            in_valid = $urandom_range(0, 1);
            a_vec    = ROWS*DATA_W'($urandom);
            b_vec    = COLS*DATA_W'($urandom);
            case (smode)
                0:       c_ready = 1'b1;
                1:       c_ready = ($urandom_range(0, 2) != 0);
                default: c_ready = (stall_cnt >= 5);
            endcase
            if (c_valid) begin
                stall_cnt++;
                chk("in_ready_drain", in_ready, 0);
                if (exp_q.size() == 0) chk("exp_empty", 1, 0);
                else if (c_ready) begin
                    chk("c_row", c_row, exp_q.pop_front());
                    chk("c_row_idx", c_row_idx, exp_idx_q[0]);
                    chk("c_last", c_last, exp_idx_q.pop_front() == ROWS - 1);
                    beats++;
                end else if (smode == 2) begin
                    chk("stall_row", c_row, exp_q[0]);
                    chk("stall_idx", c_row_idx, exp_idx_q[0]);
                end
            end
            @(negedge clk);
            cyc++;
        end
        c_ready  = 1'b0;
        in_valid = 1'b0;
        chk("beats", beats, ROWS);
        chk("done_pulse", done, 1);
        chk("busy_at_done", busy, 1);
        chk("c_valid_at_done", c_valid, 0);
        @(negedge clk);
        chk("done_low", done, 0);
        chk("busy_idle", busy, 0);
    endtask

    task automatic reset_mid_load();
        fill_random();
        do_start(4, 1'b0);
        for (int n = 0; n < 2; n++) begin
            in_valid = 1'b1;
            drive_vec(n);
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_c_valid", c_valid, 0);
        chk("rst_c_last", c_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_c_row", c_row, 0);
        chk("rst_c_row_idx", c_row_idx, 0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_no_done", done, 0);
        rst = 1'b1;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) model_c[i][j] = '0;
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_c_valid", c_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_c_row", c_row, 0);
        chk("reset_c_last", c_last, 0);
        rst = 1'b1;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) model_c[i][j] = '0;

        for (int k = 0; k < 3; k++) begin
            a_m[0][k] = k + 1;
            a_m[1][k] = k + 11;
            b_m[k][0] = 10 * k + 2;
            b_m[k][1] = 10 * k + 3;
        end
        run_tile(3, 1'b0, 0, 0, 1'b0);
        run_tile(3, 1'b0, 1, 0, 1'b0);
        run_tile(3, 1'b0, 0, 2, 1'b1);
        run_tile(3, 1'b1, 0, 0, 1'b0);
        run_tile(0, 1'b0, 0, 0, 1'b0);

        for (int k = 0; k < KMAX; k++) begin
            for (int i = 0; i < ROWS; i++) a_m[i][k] = -32768;
            for (int j = 0; j < COLS; j++) b_m[k][j] = -32768;
        end
        run_tile(4, 1'b0, 2, 1, 1'b0);

        fill_random();
        run_tile(15, 1'b0, 2, 1, 1'b0);

        reset_mid_load();
        fill_random();
        run_tile(2, 1'b1, 2, 1, 1'b0);

        for (int t = 0; t < 8; t++) begin
            fill_random();
            run_tile($urandom_range(0, KMAX), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
